// File: rtl/avalon_wb_bridge_pkg.sv
// Shared types and constants for the Avalon-MM to Wishbone bridge.
package avalon_wb_bridge_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    // Returned as read data on timeout or bad channel; sliced to DW.
    localparam logic [63:0] ERR_WORD = '1;

    function automatic int ch_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/avalon_wb_bridge_if.sv
// Avalon-MM slave side and Wishbone master side bundled for the bridge.
interface avalon_wb_bridge_if
    import avalon_wb_bridge_pkg::*;
#(
    parameter int DW  = 8,
    parameter int AW  = 8,
    parameter int NCH = 1,
    parameter int CHB = ch_bits(NCH)
);
    logic [AW+CHB-1:0] av_address;
    logic              av_chipselect;
    logic              av_write;
    logic              av_read;
    logic [DW-1:0]     av_writedata;
    logic [DW-1:0]     av_readdata;
    logic              av_waitrequest;

    logic [AW-1:0]     wb_adr_o;
    logic [DW-1:0]     wb_dat_o;
    logic              wb_we_o;
    logic [NCH-1:0]    wb_cyc_o;
    logic [NCH-1:0]    wb_stb_o;
    logic [NCH*DW-1:0] wb_dat_i;
    logic [NCH-1:0]    wb_ack_i;

    modport slave (
        input  av_address, av_chipselect, av_write, av_read, av_writedata,
        output av_readdata, av_waitrequest,
        output wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o,
        input  wb_dat_i, wb_ack_i
    );

    modport master (
        output av_address, av_chipselect, av_write, av_read, av_writedata,
        input  av_readdata, av_waitrequest,
        input  wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o,
        output wb_dat_i, wb_ack_i
    );

endinterface

// File: rtl/avalon_wb_bridge_timeout_cnt.sv
// Wishbone ack timeout counter: clears while idle, counts while a cycle is open.
module wb_timeout_cnt #(
    parameter int TO_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    localparam int CW = $clog2(TO_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == CW'(TO_CYCLES - 1));

endmodule

// File: rtl/avalon_wb_bridge.sv
// Avalon-MM slave to multi-channel Wishbone master bridge with ack timeout
// and sticky error reporting.
module avalon_wb_bridge
    import avalon_wb_bridge_pkg::*;
#(
    parameter int DW        = 8,
    parameter int AW        = 8,
    parameter int NCH       = 1,
    parameter int TO_CYCLES = 255
) (
    input  logic                 av_clk,
    input  logic                 av_reset_n,
    avalon_wb_bridge_if.slave    bus,
    output logic                 err_o,
    input  logic                 err_clr_i
);
    localparam int CHB = ch_bits(NCH);

    state_e         state_q, state_d;
    logic [AW-1:0]  adr_q, adr_d;
    logic [DW-1:0]  dat_q, dat_d;
    logic [DW-1:0]  rdata_q, rdata_d;
    logic           we_q, we_d;
    logic [CHB-1:0] ch_q, ch_d;
    logic           err_q, err_d;

    logic           req;
    logic [CHB-1:0] ch_in;
    logic           bad_ch;
    logic [NCH-1:0] sel;
    logic [DW-1:0]  dat_sel;
    logic           ack_sel;
    logic           tc;
    logic           err_set;

    assign req    = bus.av_chipselect & (bus.av_read | bus.av_write);
    assign ch_in  = bus.av_address[AW+CHB-1:AW];
    assign bad_ch = (32'(ch_in) >= 32'(NCH));

    always_comb begin
        sel     = '0;
        dat_sel = '0;
        for (int k = 0; k < NCH; k++) begin
            if (32'(ch_q) == 32'(k)) begin
                sel[k]  = 1'b1;
                dat_sel = bus.wb_dat_i[k*DW +: DW];
            end
        end
        ack_sel = |(sel & bus.wb_ack_i);
    end

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        rdata_d = rdata_q;
        we_d    = we_q;
        ch_d    = ch_q;
        err_set = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    adr_d = bus.av_address[AW-1:0];
                    dat_d = bus.av_writedata;
                    we_d  = bus.av_write;
                    ch_d  = ch_in;
                    if (bad_ch) begin
                        rdata_d = ERR_WORD[DW-1:0];
                        err_set = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                // A late ack beats the timeout in the same cycle.
                if (ack_sel) begin
                    if (!we_q) begin
                        rdata_d = dat_sel;
                    end
                    state_d = S_DONE;
                end else if (tc) begin
                    rdata_d = ERR_WORD[DW-1:0];
                    err_set = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        err_d = err_set ? 1'b1 : (err_clr_i ? 1'b0 : err_q);
    end

    always_ff @(posedge av_clk or negedge av_reset_n) begin
        if (!av_reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge av_clk or negedge av_reset_n) begin
        if (!av_reset_n) begin
            adr_q   <= '0;
            dat_q   <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            ch_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            ch_q    <= ch_d;
            err_q   <= err_d;
        end
    end

    wb_timeout_cnt #(
        .TO_CYCLES (TO_CYCLES)
    ) u_timeout (
        .clk   (av_clk),
        .rst_n (av_reset_n),
        .clr_i (state_q != S_BUSY),
        .en_i  (state_q == S_BUSY),
        .tc_o  (tc)
    );

    assign bus.wb_cyc_o       = (state_q == S_BUSY) ? sel : '0;
    assign bus.wb_stb_o       = (state_q == S_BUSY) ? sel : '0;
    assign bus.wb_adr_o       = adr_q;
    assign bus.wb_dat_o       = dat_q;
    assign bus.wb_we_o        = we_q;
    assign bus.av_readdata    = rdata_q;
    assign bus.av_waitrequest = req & (state_q != S_DONE);
    assign err_o              = err_q;

endmodule

// File: tb/tb_avalon_wb_bridge.sv
// Directed bench for avalon_wb_bridge: NCH=3, TO_CYCLES=4, DW=AW=8.
module tb_avalon_wb_bridge;

    logic clk;
    logic rst_n;
    logic err_o;
    logic err_clr_i;

    avalon_wb_bridge_if #(.DW(8), .AW(8), .NCH(3)) bus ();

    avalon_wb_bridge #(
        .DW        (8),
        .AW        (8),
        .NCH       (3),
        .TO_CYCLES (4)
    ) dut (
        .av_clk     (clk),
        .av_reset_n (rst_n),
        .bus        (bus),
        .err_o      (err_o),
        .err_clr_i  (err_clr_i)
    );

    int n_chk;
    int n_pass;

    int ack_ch, ack_n, spur_ch, spur_n;
    int lat;
    logic [7:0] rd;
    logic [2:0] cyc_or, stb_or;
    logic done_cyc, err_done, held_wr, idle_wr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic [1:0] ch, input logic [7:0] adr,
                        input logic rd_en, input logic wr_en,
                        input logic [7:0] wd);
        int busy;
        bus.av_address    = {ch, adr};
        bus.av_writedata  = wd;
        bus.av_read       = rd_en;
        bus.av_write      = wr_en;
        bus.av_chipselect = 1'b1;
        busy   = 0;
        lat    = 1;
        cyc_or = '0;
        stb_or = '0;
        #1;
        while (bus.av_waitrequest && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            bus.wb_ack_i = '0;
            if (bus.wb_cyc_o != '0) begin
                busy++;
                cyc_or |= bus.wb_cyc_o;
                stb_or |= bus.wb_stb_o;
                if (busy == ack_n) bus.wb_ack_i[ack_ch] = 1'b1;
                if (busy == spur_n) bus.wb_ack_i[spur_ch] = 1'b1;
            end
            #1;
        end
        rd       = bus.av_readdata;
        done_cyc = |bus.wb_cyc_o;
        err_done = err_o;
        @(posedge clk);
        #1;
        bus.wb_ack_i = '0;
        held_wr = bus.av_waitrequest;
        bus.av_chipselect = 1'b0;
        bus.av_read       = 1'b0;
        bus.av_write      = 1'b0;
        #1;
        idle_wr = bus.av_waitrequest;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst_n = 1'b0;
        err_clr_i = 1'b0;
        bus.av_address    = '0;
        bus.av_chipselect = 1'b0;
        bus.av_read       = 1'b0;
        bus.av_write      = 1'b0;
        bus.av_writedata  = '0;
        bus.wb_ack_i      = '0;
        bus.wb_dat_i      = {8'h33, 8'h5A, 8'hA5};
        ack_ch = 0; ack_n = 0; spur_ch = 0; spur_n = 0;

        #3;
        chk("rst_wr", bus.av_waitrequest, 0);
        chk("rst_cyc", bus.wb_cyc_o, 0);
        chk("rst_stb", bus.wb_stb_o, 0);
        chk("rst_we", bus.wb_we_o, 0);
        chk("rst_adr", bus.wb_adr_o, 0);
        chk("rst_dat", bus.wb_dat_o, 0);
        chk("rst_rdata", bus.av_readdata, 0);
        chk("rst_err", err_o, 0);
        #9;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // read ch1, ack in second BUSY cycle
        ack_ch = 1; ack_n = 2; spur_n = 0;
        xfer(2'd1, 8'h10, 1'b1, 1'b0, 8'h00);
        chk("rd1_lat", lat, 4);
        chk("rd1_data", rd, 8'h5A);
        chk("rd1_stb", stb_or, 3'b010);
        chk("rd1_cyc", cyc_or, 3'b010);
        chk("rd1_adr", bus.wb_adr_o, 8'h10);
        chk("rd1_we", bus.wb_we_o, 0);
        chk("rd1_err", err_done, 0);
        chk("rd1_done_cyc", done_cyc, 0);
        chk("rd1_held_wr", held_wr, 1);
        chk("rd1_idle_wr", idle_wr, 0);

        // write ch0, ack in first BUSY cycle
        ack_ch = 0; ack_n = 1;
        xfer(2'd0, 8'h03, 1'b0, 1'b1, 8'hC3);
        chk("wr0_lat", lat, 3);
        chk("wr0_we", bus.wb_we_o, 1);
        chk("wr0_dat", bus.wb_dat_o, 8'hC3);
        chk("wr0_adr", bus.wb_adr_o, 8'h03);
        chk("wr0_stb", stb_or, 3'b001);
        chk("wr0_rdata", rd, 8'h5A);

        // read and write both high -> write
        ack_ch = 2; ack_n = 1;
        xfer(2'd2, 8'h44, 1'b1, 1'b1, 8'h77);
        chk("rw_lat", lat, 3);
        chk("rw_we", bus.wb_we_o, 1);
        chk("rw_dat", bus.wb_dat_o, 8'h77);
        chk("rw_stb", stb_or, 3'b100);
        chk("rw_rdata", rd, 8'h5A);

        // timeout: no ack
        ack_n = 0;
        xfer(2'd0, 8'h07, 1'b1, 1'b0, 8'h00);
        chk("to_lat", lat, 6);
        chk("to_data", rd, 8'hFF);
        chk("to_err", err_done, 1);
        chk("to_stb", stb_or, 3'b001);
        chk("to_err_sticky", err_o, 1);
        err_clr_i = 1'b1;
        @(posedge clk);
        #1;
        err_clr_i = 1'b0;
        chk("to_err_clr", err_o, 0);

        // bad channel with clear held: set wins, then clear
        err_clr_i = 1'b1;
        xfer(2'd3, 8'h20, 1'b1, 1'b0, 8'h00);
        err_clr_i = 1'b0;
        chk("bad_lat", lat, 2);
        chk("bad_cyc", cyc_or, 3'b000);
        chk("bad_data", rd, 8'hFF);
        chk("bad_err", err_done, 1);
        chk("bad_err_clr", err_o, 0);

        // stray ack on ch0, real ack on ch1 at the timeout cycle
        ack_ch = 1; ack_n = 4; spur_ch = 0; spur_n = 1;
        xfer(2'd1, 8'h10, 1'b1, 1'b0, 8'h00);
        spur_n = 0;
        chk("late_lat", lat, 6);
        chk("late_data", rd, 8'h5A);
        chk("late_err", err_done, 0);
        chk("late_stb", stb_or, 3'b010);

        // reset during BUSY
        ack_n = 0;
        bus.av_address    = {2'd2, 8'h55};
        bus.av_read       = 1'b1;
        bus.av_chipselect = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_cyc", bus.wb_cyc_o, 3'b100);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cyc", bus.wb_cyc_o, 0);
        chk("mid_rst_stb", bus.wb_stb_o, 0);
        chk("mid_rst_adr", bus.wb_adr_o, 0);
        chk("mid_rst_rdata", bus.av_readdata, 0);
        chk("mid_rst_wr", bus.av_waitrequest, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rel_wr", bus.av_waitrequest, 1);
        bus.av_chipselect = 1'b0;
        bus.av_read       = 1'b0;
        #1;
        chk("rel_idle_wr", bus.av_waitrequest, 0);
        @(posedge clk);
        #1;

        ack_ch = 0; ack_n = 1;
        xfer(2'd0, 8'h21, 1'b0, 1'b1, 8'h9C);
        chk("post_lat", lat, 3);
        chk("post_dat", bus.wb_dat_o, 8'h9C);
        chk("post_adr", bus.wb_adr_o, 8'h21);
        chk("post_we", bus.wb_we_o, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/avalon_wb_bridge.md
AVALON_WB_BRIDGE -- requirements
Module: avalon_wb_bridge

Interface
REQ-001 SHALL have parameter DW, default 8: data width of the Avalon and Wishbone data buses.
REQ-002 SHALL have parameter AW, default 8: Wishbone address width per channel.
REQ-003 SHALL have parameter NCH, default 1: number of Wishbone slave channels; CHB = max(1, clog2(NCH)).
REQ-004 SHALL have parameter TO_CYCLES, default 255: number of Wishbone cycles without ack before timeout.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 av_clk  in  1  sole clock; all logic on its rising edge.
REQ-007 av_reset_n  in  1  asynchronous active-low reset.
REQ-008 av_address  in  AW+CHB  [AW+CHB-1:AW] is the channel index; [AW-1:0] is the register address.
REQ-009 av_chipselect, av_write, av_read  in  1 each  Avalon-MM slave request qualifiers.
REQ-010 av_writedata  in  DW  write data.
REQ-011 av_readdata  out  DW  registered read data, valid in the cycle av_waitrequest is low.
REQ-012 av_waitrequest  out  1  active-high stall.
REQ-013 wb_adr_o  out  AW  latched register address, shared by all channels.
REQ-014 wb_dat_o  out  DW  latched write data.
REQ-015 wb_we_o  out  1  latched write strobe.
REQ-016 wb_cyc_o, wb_stb_o  out  NCH each  one-hot per-channel cycle/strobe.
REQ-017 wb_dat_i  in  NCH*DW  per-channel read data; channel k occupies [k*DW +: DW].
REQ-018 wb_ack_i  in  NCH  per-channel ack.
REQ-019 err_o  out  1  sticky error flag (timeout or bad channel).
REQ-020 err_clr_i  in  1  synchronous clear of err_o.

Function
REQ-021 SHALL implement an FSM with states IDLE, BUSY, DONE.
REQ-022 IDLE: on av_chipselect & (av_read | av_write), SHALL latch address, data, we (= av_write) and channel, then go to BUSY; if av_read and av_write are both high, the access SHALL be a write.
REQ-023 IDLE with channel index >= NCH: SHALL go directly to DONE, return all-ones read data, set err_o, and assert no wb_cyc_o bit.
REQ-024 BUSY: wb_cyc_o[ch] and wb_stb_o[ch] SHALL be high and all other bits low; timeout counter SHALL increment every cycle from 0.
REQ-025 BUSY with wb_ack_i[ch] high: SHALL register wb_dat_i channel ch into av_readdata (reads only; unchanged on writes) and go to DONE.
REQ-026 Acks on non-selected channels SHALL be ignored.
REQ-027 BUSY with counter == TO_CYCLES-1 and no ack: SHALL go to DONE, set av_readdata to all ones, and set err_o.
REQ-028 Ack in the same cycle as timeout SHALL win; err_o is not set.
REQ-029 DONE: av_waitrequest SHALL be low for exactly one cycle, cyc/stb SHALL be low, and next state SHALL be IDLE.
REQ-030 av_waitrequest SHALL be high whenever av_chipselect & (av_read | av_write) and state != DONE; otherwise low.
REQ-031 Minimum latency SHALL be 3 cycles from request to waitrequest low (ack in the first BUSY cycle); back-to-back requests add one IDLE cycle.
REQ-032 err_o SHALL set on any error event; err_clr_i SHALL clear it; a simultaneous set SHALL win over clear.
REQ-033 A request deasserted while in BUSY SHALL still complete its Wishbone cycle; the DONE result is then discarded.

Reset
REQ-034 On av_reset_n low, SHALL asynchronously force state to IDLE and counter to 0.
REQ-035 On av_reset_n low, wb_cyc_o, wb_stb_o and wb_we_o SHALL go to 0, wb_adr_o and wb_dat_o to 0, av_readdata to 0, and err_o to 0.
REQ-036 Reset mid-cycle SHALL abort without a DONE pulse; av_waitrequest SHALL follow REQ-030 after release.

Structure
REQ-037 A shared package SHALL hold the FSM state enum and the all-ones error pattern constant.
REQ-038 The timeout counter SHALL be one sub-module, wb_timeout_cnt (width clog2(TO_CYCLES+1), with clear and terminal-count output).

Verification
REQ-039 NCH=2, read addr {ch1,0x10}, slave acks after 2 cycles with 0x5A -> wb_stb_o=2'b10, av_readdata=0x5A, waitrequest low on cycle 4, err_o=0.
REQ-040 Write 0xC3 to {ch0,0x03}, ack in the first BUSY cycle -> wb_we_o=1, wb_dat_o=0xC3, wb_adr_o=0x03, 3-cycle latency.
REQ-041 TO_CYCLES=4, read with no ack -> DONE after 4 BUSY cycles, av_readdata=0xFF, err_o=1; err_clr_i pulse -> err_o=0.
REQ-042 NCH=3, read channel 3 -> no cyc asserted, readdata=0xFF, err_o=1, 2-cycle latency.
REQ-043 Ack on ch0 while ch1 is selected -> ignored; then ack on ch1 exactly at timeout -> data returned, err_o=0.
REQ-044 av_reset_n low during BUSY -> wb_cyc_o=0 immediately; next request completes normally.
